spgd_update_ctrl: RTL and testbench
===================================

# spgd_update_ctrl

Datapath controller for the SPGD loop. It sits between the ADC/DAC sample path and the loop sequencer, and acts on the sequencer's one-cycle strobes. It captures the metric samples J+ and J−, computes the gradient step, updates the control word U with saturation, and drives the DAC with off / U+δ / U−δ / U according to the sequencer's DAC select. It also generates the perturbation sign for each iteration.

## Interface
- `DW`, default 14: ADC/DAC sample width; all signed two's complement.
- `SHW`, default 4: width of `gain_shift`.
- `adc_clk` in 1: sole clock; all logic on rising edge.
- `adc_rstn` in 1: asynchronous, active-low reset.
- `adc_dat` in DW: signed metric sample from the ADC path.
- `fsm_jp_wrt` in 1: one-cycle strobe; capture J+.
- `fsm_jm_wrt` in 1: one-cycle strobe; capture J−.
- `fsm_u_wrt` in 1: one-cycle strobe; start a U update.
- `fsm_reg_rst` in 1: level; clear J registers.
- `fsm_dac_sel` in 2: 00 off, 01 U+s·δ, 10 U−s·δ, 11 U.
- `pert_amp` in DW: perturbation magnitude δ, unsigned, MSB ignored (0..2^(DW−1)−1).
- `gain_shift` in SHW: arithmetic right shift applied to the gradient.
- `dac_dat` out DW: registered DAC code.
- `u_out` out DW: current control word U.
- `j_plus`, `j_minus` out DW: captured metric samples.
- `pert_sign` out 1: current sign s (0 → +1, 1 → −1).
- `u_valid` out 1: one-cycle pulse when the new U is committed.
- `busy` out 1: high while an update is in the pipeline.
- `sat` out 1: sticky flag; a U or DAC result clipped.
- `overrun` out 1: sticky flag; `fsm_u_wrt` arrived while `busy`.

## Operation
- **Capture.**
  - `fsm_jp_wrt` → `j_plus <= adc_dat`.
  - `fsm_jm_wrt` → `j_minus <= adc_dat`.
  - If both strobes are high in the same cycle, both registers load the same sample.
  - `fsm_reg_rst` high clears `j_plus` and `j_minus` to 0 and takes priority over capture. It does not touch U, the sign, flags or the pipeline.
- **Update pipeline.** Control is a 4-state FSM: IDLE → S1 → S2 → S3 → IDLE. `busy` = state ≠ IDLE. `fsm_u_wrt` in IDLE → S1.
  - S1: `dj <= j_plus − j_minus`, DW+1 bits signed. Range ±(2^DW−1); no overflow possible.
  - S2: `step <= (pert_sign ? −dj : dj) >>> gain_shift`, DW+1 bits, arithmetic shift. Negation cannot overflow.
  - S3: `u_out <= sat(u_out + step)`. The sum is computed in DW+2 bits and clipped to [−2^(DW−1), 2^(DW−1)−1]; `sat` is set if clipped. `u_valid` pulses in S3. The perturbation sign advances in the same cycle.
- **Retrigger.** `fsm_u_wrt` while `busy` is ignored and sets `overrun`. J registers sampled in S1 are used; a capture strobe during S2/S3 affects only the next update.
- **DAC mux** (registered), with sum = DW+1 bits, saturated, `sat` set on clip:
  - 00 → 0.
  - 01 → sat(U + s·δ).
  - 10 → sat(U − s·δ).
  - 11 → U.
  - U and s are the values current at the sampling edge.
- **Flags.** `sat` and `overrun` clear only on reset.

## Timing
- **Reset values.** `dac_dat`=0, `u_out`=0, `j_plus`=`j_minus`=0, `pert_sign`=0, `u_valid`=0, `busy`=0, `sat`=0, `overrun`=0; FSM IDLE; LFSR = 16'hACE1.
- **Capture:** J registers update on the edge where the strobe is sampled high, so they are visible the next cycle.
- **Update:** `fsm_u_wrt` sampled at edge N → `busy` high after N. `u_out` and `pert_sign` change and `u_valid` is high after edge N+3. `busy` low after N+3. A new `fsm_u_wrt` is accepted at edge N+3.
- **DAC:** `dac_dat` reflects `fsm_dac_sel` and U one edge after sampling.
- **Reset mid-update:** the pipeline aborts to IDLE immediately with all reset values; no partial U commit.

## Configuration
- `SPGD_RANDOM_PERT_EN`
  - **Defined:** `pert_sign` = bit 0 of a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1. The LFSR shifts once per committed update.
  - **Undefined:** no LFSR is built; `pert_sign` toggles on each committed update (deterministic dither).
  - Everything else is identical in both builds.

## Test plan
- **Capture and gradient step.** `adc_dat`=100 with `fsm_jp_wrt`, then `adc_dat`=40 with `fsm_jm_wrt`; `gain_shift`=2; s=+1; pulse `fsm_u_wrt` → `u_out`=15 and `u_valid` one cycle at N+3; `busy` high for 3 cycles.
- **Negative sign and arithmetic shift.** Set s=−1 (macro undefined, after one update); J+=−8, J−=7; `gain_shift`=1 → step=+7 (15>>>1); U increases by 7.
- **Upper saturation.** Preload U near 8191; J+=8191, J−=−8192; `gain_shift`=0 → `u_out`=8191 and `sat`=1. Mirror case clips to −8192.
- **DAC mux.** U=8000, δ=500, s=+1:
  - sel 01 → 8191, `sat` set.
  - sel 10 → 7500.
  - sel 11 → 8000.
  - sel 00 → 0.
  - Each appears one cycle after sel changes.
- **Overrun.** Pulse `fsm_u_wrt` at N and again at N+1 → single update; `overrun`=1; U changes once.
- **Reset mid-operation.** Deassert `adc_rstn` during S2 → all outputs at reset values asynchronously; `fsm_reg_rst` clears J only, with U retained.

Source files
------------

// File: rtl/spgd_update_ctrl.sv
// spgd_update_ctrl: SPGD loop datapath controller.
// Captures J+/J-, forms the gradient step, updates the control word U with
// saturation, drives the DAC mux, and generates the perturbation sign.
// Build option: define SPGD_RANDOM_PERT_EN to draw the sign from a 16-bit
// LFSR; otherwise the sign toggles on every committed update.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | waiting for fsm_u_wrt
// ST_S1   | register dj = j_plus - j_minus
// ST_S2   | register step = (+/-dj) >>> gain_shift
// ST_S3   | commit saturated U, pulse u_valid, advance sign
module spgd_update_ctrl #(
  parameter int DW  = 14,
  parameter int SHW = 4
) (
  input  logic                 adc_clk,
  input  logic                 adc_rstn,
  input  logic signed [DW-1:0] adc_dat,
  input  logic                 fsm_jp_wrt,
  input  logic                 fsm_jm_wrt,
  input  logic                 fsm_u_wrt,
  input  logic                 fsm_reg_rst,
  input  logic [1:0]           fsm_dac_sel,
  input  logic [DW-1:0]        pert_amp,
  input  logic [SHW-1:0]       gain_shift,
  output logic signed [DW-1:0] dac_dat,
  output logic signed [DW-1:0] u_out,
  output logic signed [DW-1:0] j_plus,
  output logic signed [DW-1:0] j_minus,
  output logic                 pert_sign,
  output logic                 u_valid,
  output logic                 busy,
  output logic                 sat,
  output logic                 overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_S1   = 2'd1;
  localparam logic [1:0] ST_S2   = 2'd2;
  localparam logic [1:0] ST_S3   = 2'd3;

  localparam logic signed [DW-1:0] U_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] U_MIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0] SUM_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SUM_MIN = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [DW:0]   DAC_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   DAC_MIN = {2'b11, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        AMP_MASK = {1'b0, {(DW-1){1'b1}}};

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic signed [DW:0]   dj;
  logic signed [DW:0]   step;
  logic signed [DW:0]   dj_next;
  logic signed [DW:0]   dj_signed;
  logic signed [DW:0]   step_next;
  logic signed [DW+1:0] u_sum;
  logic signed [DW-1:0] u_clip;
  logic                 u_clip_hit;
  logic signed [DW:0]   delta;
  logic signed [DW:0]   dac_add;
  logic signed [DW:0]   dac_sum;
  logic signed [DW-1:0] dac_next;
  logic                 dac_clip_hit;
  logic                 commit;
  logic                 sign_next;

  assign busy   = (state != ST_IDLE);
  assign commit = (state == ST_S3);

  // Next-state logic; S3 can accept a fresh request straight away.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fsm_u_wrt) state_next = ST_S1;
      ST_S1:   state_next = ST_S2;
      ST_S2:   state_next = ST_S3;
      ST_S3:   state_next = fsm_u_wrt ? ST_S1 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Gradient arithmetic and saturated U sum.
  always_comb begin
    dj_next    = {j_plus[DW-1], j_plus} - {j_minus[DW-1], j_minus};
    dj_signed  = pert_sign ? -dj : dj;
    step_next  = dj_signed >>> gain_shift;
    u_sum      = {{2{u_out[DW-1]}}, u_out} + {step[DW], step};
    u_clip     = u_sum[DW-1:0];
    u_clip_hit = 1'b0;
    if (u_sum > SUM_MAX) begin
      u_clip     = U_MAX;
      u_clip_hit = 1'b1;
    end else if (u_sum < SUM_MIN) begin
      u_clip     = U_MIN;
      u_clip_hit = 1'b1;
    end
  end

  // DAC mux: off, U +/- s*delta with clipping, or U.
  always_comb begin
    delta        = {1'b0, pert_amp & AMP_MASK};
    dac_add      = '0;
    dac_sum      = '0;
    dac_next     = '0;
    dac_clip_hit = 1'b0;
    case (fsm_dac_sel)
      2'b00: dac_next = '0;
      2'b11: dac_next = u_out;
      default: begin
        if (fsm_dac_sel == 2'b01) dac_add = pert_sign ? -delta : delta;
        else                      dac_add = pert_sign ? delta : -delta;
        dac_sum  = {u_out[DW-1], u_out} + dac_add;
        dac_next = dac_sum[DW-1:0];
        if (dac_sum > DAC_MAX) begin
          dac_next     = U_MAX;
          dac_clip_hit = 1'b1;
        end else if (dac_sum < DAC_MIN) begin
          dac_next     = U_MIN;
          dac_clip_hit = 1'b1;
        end
      end
    endcase
  end

`ifdef SPGD_RANDOM_PERT_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign sign_next = lfsr_fb;

  // Perturbation LFSR, one shift per committed update.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn)   lfsr <= 16'hACE1;
    else if (commit) lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign sign_next = ~pert_sign;
`endif

  // FSM, pipeline registers, U commit and sign advance.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state     <= ST_IDLE;
      dj        <= '0;
      step      <= '0;
      u_out     <= '0;
      u_valid   <= 1'b0;
      pert_sign <= 1'b0;
    end else begin
      state   <= state_next;
      u_valid <= commit;
      if (state == ST_S1) dj   <= dj_next;
      if (state == ST_S2) step <= step_next;
      if (commit) begin
        u_out     <= u_clip;
        pert_sign <= sign_next;
      end
    end
  end

  // Metric capture; register clear wins over the strobes.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      j_plus  <= '0;
      j_minus <= '0;
    end else if (fsm_reg_rst) begin
      j_plus  <= '0;
      j_minus <= '0;
    end else begin
      if (fsm_jp_wrt) j_plus  <= adc_dat;
      if (fsm_jm_wrt) j_minus <= adc_dat;
    end
  end

  // Registered DAC output and sticky status flags.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      dac_dat <= '0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      dac_dat <= dac_next;
      if (dac_clip_hit || (commit && u_clip_hit)) sat <= 1'b1;
      if (fsm_u_wrt && (state == ST_S1 || state == ST_S2)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spgd_update_ctrl.sv
// Directed bench for spgd_update_ctrl (default build, toggling sign).
module tb_spgd_update_ctrl;

  logic               adc_clk;
  logic               adc_rstn;
  logic signed [13:0] adc_dat;
  logic               fsm_jp_wrt;
  logic               fsm_jm_wrt;
  logic               fsm_u_wrt;
  logic               fsm_reg_rst;
  logic [1:0]         fsm_dac_sel;
  logic [13:0]        pert_amp;
  logic [3:0]         gain_shift;
  logic signed [13:0] dac_dat;
  logic signed [13:0] u_out;
  logic signed [13:0] j_plus;
  logic signed [13:0] j_minus;
  logic               pert_sign;
  logic               u_valid;
  logic               busy;
  logic               sat;
  logic               overrun;

  int n_pass  = 0;
  int n_total = 0;

  spgd_update_ctrl #(.DW(14), .SHW(4)) dut (
    .adc_clk     (adc_clk),
    .adc_rstn    (adc_rstn),
    .adc_dat     (adc_dat),
    .fsm_jp_wrt  (fsm_jp_wrt),
    .fsm_jm_wrt  (fsm_jm_wrt),
    .fsm_u_wrt   (fsm_u_wrt),
    .fsm_reg_rst (fsm_reg_rst),
    .fsm_dac_sel (fsm_dac_sel),
    .pert_amp    (pert_amp),
    .gain_shift  (gain_shift),
    .dac_dat     (dac_dat),
    .u_out       (u_out),
    .j_plus      (j_plus),
    .j_minus     (j_minus),
    .pert_sign   (pert_sign),
    .u_valid     (u_valid),
    .busy        (busy),
    .sat         (sat),
    .overrun     (overrun)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic cap(input int v, input logic p, input logic m);
    adc_dat    = 14'(v);
    fsm_jp_wrt = p;
    fsm_jm_wrt = m;
    tick();
    fsm_jp_wrt = 1'b0;
    fsm_jm_wrt = 1'b0;
  endtask

  task automatic do_update(input string tag);
    fsm_u_wrt = 1'b1;
    tick();
    fsm_u_wrt = 1'b0;
    tick();
    tick();
    tick();
    chk({tag, "_valid"}, u_valid, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic hard_reset;
    adc_rstn = 1'b0;
    tick();
    adc_rstn = 1'b1;
    tick();
  endtask

  initial begin
    adc_rstn    = 1'b1;
    adc_dat     = '0;
    fsm_jp_wrt  = 1'b0;
    fsm_jm_wrt  = 1'b0;
    fsm_u_wrt   = 1'b0;
    fsm_reg_rst = 1'b0;
    fsm_dac_sel = 2'b00;
    pert_amp    = '0;
    gain_shift  = '0;
    #2;
    adc_rstn = 1'b0;
    tick();
    tick();
    chk("rst_dac", dac_dat, 0);
    chk("rst_u", u_out, 0);
    chk("rst_jp", j_plus, 0);
    chk("rst_jm", j_minus, 0);
    chk("rst_sign", pert_sign, 0);
    chk("rst_valid", u_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovr", overrun, 0);
    adc_rstn = 1'b1;
    tick();

    // Capture and gradient step: (100-40)>>>2 = 15
    cap(100, 1'b1, 1'b0);
    chk("cap_jp", j_plus, 100);
    cap(40, 1'b0, 1'b1);
    chk("cap_jm", j_minus, 40);
    chk("cap_jp_hold", j_plus, 100);
    gain_shift = 4'd2;
    fsm_u_wrt  = 1'b1;
    tick();
    fsm_u_wrt = 1'b0;
    chk("t1_busy_n0", busy, 1);
    chk("t1_valid_n0", u_valid, 0);
    tick();
    chk("t1_busy_n1", busy, 1);
    tick();
    chk("t1_busy_n2", busy, 1);
    chk("t1_u_n2", u_out, 0);
    tick();
    chk("t1_busy_n3", busy, 0);
    chk("t1_valid_n3", u_valid, 1);
    chk("t1_u", u_out, 15);
    chk("t1_sign", pert_sign, 1);
    tick();
    chk("t1_valid_pulse", u_valid, 0);

    // Negative sign: -(-8-7)>>>1 = 7, U = 22
    cap(-8, 1'b1, 1'b0);
    cap(7, 1'b0, 1'b1);
    gain_shift = 4'd1;
    do_update("t2");
    chk("t2_u", u_out, 22);
    chk("t2_sign", pert_sign, 0);
    chk("t2_sat", sat, 0);

    // Upper saturation: 22 + 16383 -> 8191
    cap(8191, 1'b1, 1'b0);
    cap(-8192, 1'b0, 1'b1);
    gain_shift = 4'd0;
    do_update("t3");
    chk("t3_u", u_out, 8191);
    chk("t3_sat", sat, 1);

    // Reset during S2: asynchronous clear, no partial commit
    cap(50, 1'b1, 1'b0);
    fsm_u_wrt = 1'b1;
    tick();
    fsm_u_wrt = 1'b0;
    tick();
    chk("t6_busy_s2", busy, 1);
    adc_rstn = 1'b0;
    #1;
    chk("t6_u", u_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sat", sat, 0);
    chk("t6_sign", pert_sign, 0);
    chk("t6_jp", j_plus, 0);
    tick();
    adc_rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_u_after", u_out, 0);
    chk("t6_valid_after", u_valid, 0);

    // Lower saturation: 0 - 16383 -> -8192
    cap(-8192, 1'b1, 1'b0);
    cap(8191, 1'b0, 1'b1);
    do_update("t3m");
    chk("t3m_u", u_out, -8192);
    chk("t3m_sat", sat, 1);

    // J clear leaves U, sign and flags; clear wins over capture
    cap(5, 1'b1, 1'b0);
    cap(6, 1'b0, 1'b1);
    fsm_reg_rst = 1'b1;
    tick();
    fsm_reg_rst = 1'b0;
    chk("rr_jp", j_plus, 0);
    chk("rr_jm", j_minus, 0);
    chk("rr_u", u_out, -8192);
    chk("rr_sign", pert_sign, 1);
    chk("rr_sat", sat, 1);
    fsm_reg_rst = 1'b1;
    cap(77, 1'b1, 1'b1);
    fsm_reg_rst = 1'b0;
    chk("rr_prio", j_plus, 0);
    cap(33, 1'b1, 1'b1);
    chk("both_jp", j_plus, 33);
    chk("both_jm", j_minus, 33);

    // DAC mux with U=8000, delta=500, s=+1
    hard_reset();
    cap(8000, 1'b1, 1'b0);
    do_update("dac_pre1");
    fsm_reg_rst = 1'b1;
    tick();
    fsm_reg_rst = 1'b0;
    do_update("dac_pre2");
    chk("dac_u", u_out, 8000);
    chk("dac_sign", pert_sign, 0);
    chk("dac_sat0", sat, 0);
    pert_amp    = 14'd500;
    fsm_dac_sel = 2'b01;
    chk("dac_lat", dac_dat, 0);
    tick();
    chk("dac_01", dac_dat, 8191);
    chk("dac_01_sat", sat, 1);
    fsm_dac_sel = 2'b10;
    tick();
    chk("dac_10", dac_dat, 7500);
    fsm_dac_sel = 2'b11;
    tick();
    chk("dac_11", dac_dat, 8000);
    fsm_dac_sel = 2'b00;
    tick();
    chk("dac_00", dac_dat, 0);

    // Overrun: second request at N+1 is dropped
    cap(10, 1'b1, 1'b0);
    chk("ovr_pre", overrun, 0);
    fsm_u_wrt = 1'b1;
    tick();
    tick();
    fsm_u_wrt = 1'b0;
    chk("ovr_flag", overrun, 1);
    tick();
    tick();
    chk("ovr_u", u_out, 8010);
    chk("ovr_valid", u_valid, 1);
    tick();
    tick();
    tick();
    tick();
    chk("ovr_u_once", u_out, 8010);
    chk("ovr_idle", busy, 0);
    chk("ovr_sticky", overrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
